// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate selects, writeback
// sources and the control bundle carried through the ID/EX register.
package rv_pkg;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // Immediate-generator select encodings
  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_SH    = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_LUI   = 3'd4;
  localparam logic [2:0] IMM_AUIPC = 3'd5;
  localparam logic [2:0] IMM_J     = 3'd6;
  localparam logic [2:0] IMM_LD    = 3'd7;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Decoded control carried from ID into EX
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // All-zero control word used for bubbles and empty slots
  localparam ctrl_t CTRL_NOP = '0;

  // True for OP-IMM shift encodings (SLLI / SRLI / SRAI)
  function automatic logic is_shift_imm(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: immediate select, source register usage and
// the control bundle for the instruction sitting in IF/ID.
module id_decode
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  imm_sel,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd_field;
  logic       writes_rd;
  ctrl_t      ctrl_raw;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign funct7_b5 = inst[30];
  assign rd_field  = inst[11:7];

  // Opcode decode into immediate select, register usage and raw control
  always_comb begin
    imm_sel   = IMM_I;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    ctrl_raw  = CTRL_NOP;
    ctrl_raw.alu_op = {1'b0, funct3};
    unique case (opcode)
      OP: begin
        uses_rs2           = 1'b1;
        writes_rd          = 1'b1;
        ctrl_raw.alu_src_b = 1'b0;
        ctrl_raw.alu_op    = {funct7_b5, funct3};
        ctrl_raw.wb_sel    = WB_ALU;
      end
      OP_IMM: begin
        imm_sel            = is_shift_imm(funct3) ? IMM_SH : IMM_I;
        writes_rd          = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
        // inst[30] is an immediate bit for everything except SRAI
        ctrl_raw.alu_op    = {(funct3 == 3'b101) & funct7_b5, funct3};
        ctrl_raw.wb_sel    = WB_ALU;
      end
      LOAD: begin
        imm_sel            = IMM_LD;
        writes_rd          = 1'b1;
        ctrl_raw.mem_rd    = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
        ctrl_raw.wb_sel    = WB_MEM;
      end
      STORE: begin
        imm_sel            = IMM_S;
        uses_rs2           = 1'b1;
        ctrl_raw.mem_wr    = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
      end
      BRANCH: begin
        imm_sel            = IMM_B;
        uses_rs2           = 1'b1;
        ctrl_raw.branch    = 1'b1;
        ctrl_raw.alu_src_b = 1'b0;
      end
      JAL: begin
        imm_sel            = IMM_J;
        uses_rs1           = 1'b0;
        writes_rd          = 1'b1;
        ctrl_raw.jump      = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
        ctrl_raw.wb_sel    = WB_PC4;
      end
      JALR: begin
        imm_sel            = IMM_LD;
        writes_rd          = 1'b1;
        ctrl_raw.jump      = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
        ctrl_raw.wb_sel    = WB_PC4;
      end
      LUI: begin
        imm_sel            = IMM_LUI;
        uses_rs1           = 1'b0;
        writes_rd          = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
      end
      AUIPC: begin
        imm_sel            = IMM_AUIPC;
        uses_rs1           = 1'b0;
        writes_rd          = 1'b1;
        ctrl_raw.alu_src_b = 1'b1;
      end
      default: begin
        ctrl_raw.illegal = 1'b1;
        ctrl_raw.alu_op  = 4'd0;
      end
    endcase
  end

  // rd is only meaningful for writers; x0 destinations never write
  always_comb begin
    ctrl        = ctrl_raw;
    ctrl.rd     = writes_rd ? rd_field : 5'd0;
    ctrl.reg_wr = writes_rd & (rd_field != 5'd0);
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: load-use hazard detection, the ID/EX control
// register with flush / hold / bubble handling, and saturating event counters.
module id_stage_ctrl
  import rv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             ex_flush,
  input  logic             ext_stall,
  output logic [2:0]       imm_sel,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_wr,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_alu_src_b,
  output logic [3:0]       ex_alu_op,
  output logic [1:0]       ex_wb_sel,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       uses_rs1;
  logic       uses_rs2;
  ctrl_t      id_ctrl;
  ctrl_t      ex_ctrl;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       raw_haz;

  id_decode u_decode (
    .inst     (id_inst),
    .imm_sel  (imm_sel),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .ctrl     (id_ctrl)
  );

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    raw_haz = id_valid & ex_valid & ex_ctrl.mem_rd & (ex_ctrl.rd != 5'd0) &
              ((uses_rs1 & (ex_ctrl.rd == id_rs1)) |
               (uses_rs2 & (ex_ctrl.rd == id_rs2)));
    // A flush or back-end stall already stops IF/ID, so no extra request
    hazard_stall = raw_haz & ~ex_flush & ~ext_stall;
  end

  // ID/EX register: reset > flush > hold > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (ext_stall) begin
      ex_valid <= ex_valid;
      ex_ctrl  <= ex_ctrl;
    end else if (raw_haz) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  // Saturating stall / flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ex_flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign ex_rd        = ex_ctrl.rd;
  assign ex_reg_wr    = ex_ctrl.reg_wr;
  assign ex_mem_rd    = ex_ctrl.mem_rd;
  assign ex_mem_wr    = ex_ctrl.mem_wr;
  assign ex_alu_src_b = ex_ctrl.alu_src_b;
  assign ex_alu_op    = ex_ctrl.alu_op;
  assign ex_wb_sel    = ex_ctrl.wb_sel;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_jump      = ex_ctrl.jump;
  assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: a vector table of per-cycle inputs
// with expected combinational outputs and expected ID/EX state one cycle
// later (via a scoreboard queue), plus counter-saturation sequences.
module tb_id_stage_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic             ex_flush;
  logic             ext_stall;
  logic [2:0]       imm_sel;
  logic             hazard_stall;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_reg_wr;
  logic             ex_mem_rd;
  logic             ex_mem_wr;
  logic             ex_alu_src_b;
  logic [3:0]       ex_alu_op;
  logic [1:0]       ex_wb_sel;
  logic             ex_branch;
  logic             ex_jump;
  logic             ex_illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  id_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_inst      (id_inst),
    .ex_flush     (ex_flush),
    .ext_stall    (ext_stall),
    .imm_sel      (imm_sel),
    .hazard_stall (hazard_stall),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_reg_wr    (ex_reg_wr),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_wr    (ex_mem_wr),
    .ex_alu_src_b (ex_alu_src_b),
    .ex_alu_op    (ex_alu_op),
    .ex_wb_sel    (ex_wb_sel),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_illegal   (ex_illegal),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       mrd;
    logic       mwr;
    logic       srcb;
    logic [3:0] op;
    logic [1:0] wb;
    logic       br;
    logic       jmp;
    logic       ill;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic [31:0] inst;
    logic        flush;
    logic        stall;
    logic [2:0]  imm;
    logic        haz;
    exp_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDI   = 32'h00500093;
  localparam logic [31:0] I_SLLI   = 32'h00309113;
  localparam logic [31:0] I_JAL0   = 32'h0000006F;
  localparam logic [31:0] I_LW     = 32'h0000A283;
  localparam logic [31:0] I_ADD    = 32'h00128333;
  localparam logic [31:0] I_SW     = 32'h0050A223;
  localparam logic [31:0] I_BEQ    = 32'h00208063;
  localparam logic [31:0] I_LUI    = 32'h123453B7;
  localparam logic [31:0] I_AUIPC  = 32'h00001417;
  localparam logic [31:0] I_JALR   = 32'h000100E7;
  localparam logic [31:0] I_SRAI   = 32'h4020D193;
  localparam logic [31:0] I_SUB    = 32'h40208233;
  localparam logic [31:0] I_ADDI30 = 32'h40000093;
  localparam logic [31:0] I_LWX0   = 32'h0000A003;
  localparam logic [31:0] I_ADDX0  = 32'h00000333;
  localparam logic [31:0] I_LUIRS5 = 32'h000283B7;
  localparam logic [31:0] I_ILL    = 32'h0000007F;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t act;
  int   n_cmp = 0;
  int   n_bad = 0;

  assign act = {ex_valid, ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_alu_src_b,
                ex_alu_op, ex_wb_sel, ex_branch, ex_jump, ex_illegal,
                stall_cnt, flush_cnt};

  function automatic exp_t mk(input int v, input int rd, input int wr, input int mrd,
                              input int mwr, input int srcb, input int op, input int wb,
                              input int br, input int jmp, input int ill,
                              input int sc, input int fc);
    exp_t r;
    r.v = v[0]; r.rd = rd[4:0]; r.wr = wr[0]; r.mrd = mrd[0]; r.mwr = mwr[0];
    r.srcb = srcb[0]; r.op = op[3:0]; r.wb = wb[1:0]; r.br = br[0];
    r.jmp = jmp[0]; r.ill = ill[0]; r.sc = sc[3:0]; r.fc = fc[3:0];
    return r;
  endfunction

  function automatic exp_t e_bub(input int sc, input int fc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, fc);
  endfunction
  function automatic exp_t e_lw(input int sc, input int fc);
    return mk(1, 5, 1, 1, 0, 1, 2, 1, 0, 0, 0, sc, fc);
  endfunction
  function automatic exp_t e_add(input int sc, input int fc);
    return mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, sc, fc);
  endfunction
  function automatic exp_t e_addi(input int sc, input int fc);
    return mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, sc, fc);
  endfunction

  function automatic int sat(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  function automatic vec_t mv(input string n, input int r, input int val,
                              input logic [31:0] i, input int f, input int s,
                              input int im, input int hz, input exp_t e);
    vec_t t;
    t.name = n; t.rst = r[0]; t.valid = val[0]; t.inst = i; t.flush = f[0];
    t.stall = s[0]; t.imm = im[2:0]; t.haz = hz[0]; t.exp = e;
    return t;
  endfunction

  // Drive one cycle, check combinational outputs, queue the ID/EX expectation
  // and compare it after the edge.
  task automatic apply(input vec_t t);
    exp_t e;
    rst = t.rst; id_valid = t.valid; id_inst = t.inst;
    ex_flush = t.flush; ext_stall = t.stall;
    #1;
    n_cmp++;
    if (imm_sel !== t.imm) begin
      n_bad++;
      $display("FAIL %s imm_sel: got %0d want %0d", t.name, imm_sel, t.imm);
    end
    n_cmp++;
    if (hazard_stall !== t.haz) begin
      n_bad++;
      $display("FAIL %s hazard_stall: got %0b want %0b", t.name, hazard_stall, t.haz);
    end
    sb_q.push_back(t.exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s ex_state: got %h want %h (v rd wr mrd mwr srcb op wb br jmp ill sc fc)",
               t.name, act, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_inst = '0; ex_flush = 1'b0; ext_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    vecs.push_back(mv("addi",       0, 1, I_ADDI,   0, 0, 0, 0, e_addi(0, 0)));
    vecs.push_back(mv("slli",       0, 1, I_SLLI,   0, 0, 1, 0, mk(1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mv("jal_x0",     0, 1, I_JAL0,   0, 0, 6, 0, mk(1, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0, 0)));
    vecs.push_back(mv("lw",         0, 1, I_LW,     0, 0, 7, 0, e_lw(0, 0)));
    vecs.push_back(mv("add_haz",    0, 1, I_ADD,    0, 0, 0, 1, e_bub(1, 0)));
    vecs.push_back(mv("add_go",     0, 1, I_ADD,    0, 0, 0, 0, e_add(1, 0)));
    vecs.push_back(mv("lw_b",       0, 1, I_LW,     0, 0, 7, 0, e_lw(1, 0)));
    vecs.push_back(mv("add_flush",  0, 1, I_ADD,    1, 0, 0, 0, e_bub(1, 1)));
    vecs.push_back(mv("lw_c",       0, 1, I_LW,     0, 0, 7, 0, e_lw(1, 1)));
    vecs.push_back(mv("sw_haz",     0, 1, I_SW,     0, 0, 2, 1, e_bub(2, 1)));
    vecs.push_back(mv("sw_go",      0, 1, I_SW,     0, 0, 2, 0, mk(1, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 2, 1)));
    vecs.push_back(mv("lw_d",       0, 1, I_LW,     0, 0, 7, 0, e_lw(2, 1)));
    vecs.push_back(mv("haz_xstall", 0, 1, I_ADD,    0, 1, 0, 0, e_lw(2, 1)));
    vecs.push_back(mv("add_haz2",   0, 1, I_ADD,    0, 0, 0, 1, e_bub(3, 1)));
    vecs.push_back(mv("add_go2",    0, 1, I_ADD,    0, 0, 0, 0, e_add(3, 1)));
    vecs.push_back(mv("addi_b",     0, 1, I_ADDI,   0, 0, 0, 0, e_addi(3, 1)));
    vecs.push_back(mv("hold1",      0, 1, I_LW,     0, 1, 7, 0, e_addi(3, 1)));
    vecs.push_back(mv("hold2",      0, 1, I_LW,     0, 1, 7, 0, e_addi(3, 1)));
    vecs.push_back(mv("hold3",      0, 1, I_LW,     0, 1, 7, 0, e_addi(3, 1)));
    vecs.push_back(mv("release",    0, 1, I_LW,     0, 0, 7, 0, e_lw(3, 1)));
    vecs.push_back(mv("novalid",    0, 0, I_ADD,    0, 0, 0, 0, e_bub(3, 1)));
    vecs.push_back(mv("beq",        0, 1, I_BEQ,    0, 0, 3, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1)));
    vecs.push_back(mv("lui",        0, 1, I_LUI,    0, 0, 4, 0, mk(1, 7, 1, 0, 0, 1, 5, 0, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("auipc",      0, 1, I_AUIPC,  0, 0, 5, 0, mk(1, 8, 1, 0, 0, 1, 1, 0, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("jalr",       0, 1, I_JALR,   0, 0, 7, 0, mk(1, 1, 1, 0, 0, 1, 0, 2, 0, 1, 0, 3, 1)));
    vecs.push_back(mv("srai",       0, 1, I_SRAI,   0, 0, 1, 0, mk(1, 3, 1, 0, 0, 1, 13, 0, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("sub",        0, 1, I_SUB,    0, 0, 0, 0, mk(1, 4, 1, 0, 0, 0, 8, 0, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("addi_bit30", 0, 1, I_ADDI30, 0, 0, 0, 0, e_addi(3, 1)));
    vecs.push_back(mv("lw_x0",      0, 1, I_LWX0,   0, 0, 7, 0, mk(1, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("add_x0",     0, 1, I_ADDX0,  0, 0, 0, 0, e_add(3, 1)));
    vecs.push_back(mv("lw_e",       0, 1, I_LW,     0, 0, 7, 0, e_lw(3, 1)));
    vecs.push_back(mv("lui_rs5",    0, 1, I_LUIRS5, 0, 0, 4, 0, mk(1, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3, 1)));
    vecs.push_back(mv("illegal",    0, 1, I_ILL,    0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1)));
    vecs.push_back(mv("lw_f",       0, 1, I_LW,     0, 0, 7, 0, e_lw(3, 1)));
    vecs.push_back(mv("rst_in_haz", 1, 1, I_ADD,    0, 0, 0, 1, e_bub(0, 0)));
    vecs.push_back(mv("after_rst",  0, 1, I_ADD,    0, 0, 0, 0, e_add(0, 0)));

    foreach (vecs[k]) apply(vecs[k]);

    // Stall counter saturates at all-ones
    for (int i = 1; i <= 17; i++) begin
      apply(mv("sat_lw",  0, 1, I_LW,  0, 0, 7, 0, e_lw(sat(i - 1), 0)));
      apply(mv("sat_stl", 0, 1, I_ADD, 0, 0, 0, 1, e_bub(sat(i), 0)));
    end
    // Flush counter saturates at all-ones
    for (int i = 1; i <= 17; i++) begin
      apply(mv("sat_fls", 0, 1, I_ADDI, 1, 0, 0, 0, e_bub(15, sat(i))));
    end
    apply(mv("rst_sat", 1, 0, 32'h0, 0, 0, 0, 0, e_bub(0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage controller for the 5-stage RV32I pipeline.
- Decodes the instruction in the IF/ID register and drives the immediate-generator select (imm_sel) combinationally.
- Detects load-use hazards and owns the ID/EX control pipeline register, with bubble, hold and flush handling.
- Keeps saturating stall and flush event counters for debug/perf.

Parameters:
- CNT_W, 16, width of the stall_cnt and flush_cnt event counters.

Ports:
- clk  in  1  single pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_inst  in  32  instruction in IF/ID.
- ex_flush  in  1  branch/jump redirect resolved in EX; kill the ID instruction.
- ext_stall  in  1  back-end stall (memory busy); freeze ID/EX.
- imm_sel  out  3  immediate-generator select, combinational from id_inst.
- hazard_stall  out  1  load-use stall request to PC and IF/ID, combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_rd  out  5  destination register.
- ex_reg_wr  out  1  register-file write enable.
- ex_mem_rd  out  1  load.
- ex_mem_wr  out  1  store.
- ex_alu_src_b  out  1  ALU operand B source: 1 = immediate, 0 = rs2.
- ex_alu_op  out  4  {funct7[5], funct3}; funct7[5] forced to 0 except R-type and SRAI.
- ex_wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- ex_branch  out  1  conditional branch.
- ex_jump  out  1  JAL or JALR.
- ex_illegal  out  1  unsupported opcode.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of flush cycles.

Behaviour:
- imm_sel encoding, by opcode / funct3:
  - 0 = I-type ALU immediates (OP-IMM, except shifts).
  - 1 = shift amount (SLLI/SRLI/SRAI, OP-IMM with funct3 001 or 101).
  - 2 = S-type (store).
  - 3 = B-type (branch).
  - 4 = LUI.
  - 5 = AUIPC.
  - 6 = J-type (JAL).
  - 7 = I-type for LOAD and JALR.
  - 0 for any other opcode.
- Register use:
  - uses_rs1 for all opcodes except LUI, AUIPC, JAL.
  - uses_rs2 for OP (R-type), STORE, BRANCH only.
- Load-use hazard:
  - raw_haz = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)).
  - hazard_stall = raw_haz & !ex_flush & !ext_stall.
- ID/EX register update, in priority order at each clk edge:
  1. rst: all ex_* outputs 0 (ex_valid = 0); stall_cnt and flush_cnt = 0.
  2. ex_flush: load a bubble (ex_valid = 0, all control bits 0); flush_cnt += 1. This takes priority over ext_stall and the hazard.
  3. ext_stall: hold all ID/EX contents; no counter change.
  4. raw_haz: load a bubble; stall_cnt += 1. IF/ID is held upstream via hazard_stall.
  5. otherwise: load the decoded control; ex_valid = id_valid.
- A bubble or an id_valid = 0 slot always loads all control bits as 0.
- Illegal opcode: ex_illegal = 1 with ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch and ex_jump all 0.
- ex_rd is forced to 0 when the instruction does not write the register file (STORE, BRANCH, illegal).
- Counters saturate at all-ones; there is no wrap.
- Latency: decode appears on ex_* exactly 1 cycle after it is presented on id_inst. imm_sel has 0-cycle latency.
- Reset asserted mid-stall clears ID/EX immediately. hazard_stall drops in the same cycle because ex_valid becomes 0.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - IMM_I, IMM_SH, IMM_S, IMM_B, IMM_LUI, IMM_AUIPC, IMM_J, IMM_LD encodings (0–7);
  - WB_ALU, WB_MEM, WB_PC4.
- One combinational sub-module, id_decode, maps id_inst to imm_sel, uses_rs1/uses_rs2 and the control bundle.
- id_stage_ctrl itself contains the hazard logic, the ID/EX register and the counters.

Test Plan:
1. id_inst = 0x00500093 (ADDI x1,x0,5), id_valid = 1 → imm_sel = 0; next cycle ex_valid = 1, ex_rd = 1, ex_reg_wr = 1, ex_alu_src_b = 1, ex_wb_sel = 0.
2. id_inst = 0x00309113 (SLLI x2,x1,3) → imm_sel = 1. id_inst = 0x0000006F (JAL x0) → imm_sel = 6; next cycle ex_jump = 1, ex_rd = 0, ex_reg_wr = 0.
3. Present LW 0x0000A283, then ADD 0x00128333 → ADD cycle: hazard_stall = 1, next ex_valid = 0, stall_cnt = 1. Following cycle: hazard_stall = 0, ex_rd = 6.
4. Same as 3 but ex_flush = 1 in the hazard cycle → hazard_stall = 0, ex_valid = 0 next cycle, flush_cnt = 1, stall_cnt = 0.
5. ADDI in ID/EX, then ext_stall = 1 for 3 cycles with new id_inst → ex_* unchanged for 3 cycles, counters unchanged. Releases on the 4th cycle.
6. id_inst = 0x0000007F → ex_illegal = 1, ex_reg_wr = 0, ex_mem_wr = 0. Assert rst → all ex_* = 0 and both counters = 0 the next cycle.
